pc_register_unit: RTL and testbench
===================================

# pc_register_unit

Program-counter state element of the instruction fetch unit, directly upstream of the PC adder. Holds the current fetch address `PCResult`, drives it to the adder and instruction memory, and each cycle selects the next PC from the adder's sequential result (`PCAddResult`, PC+4), a taken-branch target or a jump target. Supports pipeline stalls, and holds any redirect that arrives during a stall so it is not lost. Traps on misaligned targets.

## Interface

Parameters:
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded by reset.
- `TRAP_VECTOR`, default 32'h0000_0080: PC value loaded on a misalignment trap.

Ports:
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-low reset. Sampled on the rising edge of `Clk`; 0 = reset.
- `PCAddResult`  in  32  sequential next PC from the PC adder (PCResult+4).
- `Jump`  in  1  jump redirect request.
- `JumpTarget`  in  32  jump destination.
- `BranchTaken`  in  1  taken-branch redirect request.
- `BranchTarget`  in  32  branch destination.
- `Stall`  in  1  freeze the PC; level-sensitive.
- `PCResult`  out  32  current fetch address; registered.
- `PCValid`  out  1  `PCResult` is a valid fetch address.
- `RedirectPending`  out  1  a redirect captured during a stall is waiting.
- `Trap`  out  1  one-cycle pulse: a misaligned target was rejected.
- `TrapPC`  out  32  the offending target from the most recent trap.

## Operation

- States:
  - RST: `Reset`=0.
  - RUN: normal fetch.
  - HOLD: `Stall`=1.
  - TRAP: one cycle after a trap.
- Any edge with `Reset`=0 enters RST. All outputs are registered and go to their reset values on that edge:
  - `PCResult`=`RESET_VECTOR`
  - `PCValid`=0
  - `RedirectPending`=0
  - `Trap`=0
  - `TrapPC`=0
  - pending register cleared.
- Reset overrides everything, including reset mid-stall or mid-trap.
- RST -> RUN on the first edge with `Reset`=1. `PCValid` becomes 1 and `PCResult` stays at `RESET_VECTOR`, so the first fetch is at the reset vector.
- Next-PC select in RUN with `Stall`=0, in priority order:
  1. `Jump`: `JumpTarget`
  2. `BranchTaken`: `BranchTarget`
  3. pending register, if `RedirectPending`=1
  4. otherwise `PCAddResult`
- A fresh redirect on the same edge overrides a pending one. Loading any PC clears `RedirectPending`.
- RUN/TRAP -> HOLD when `Stall`=1:
  - `PCResult` holds.
  - `PCValid` stays 1.
- Redirects in HOLD:
  - A redirect (`Jump` has priority over `BranchTaken`) is written to the pending register and sets `RedirectPending`.
  - A later redirect during the same stall overwrites it (latest wins).
- HOLD -> RUN on the edge where `Stall`=0, applying the select rules above.
- Arithmetic: 32-bit, no carry out. `PCAddResult` is used as delivered, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no error.
- `PCResult[1:0]` is always 2'b00 after reset.

## Timing

- Redirect latency is 1 cycle: a target presented in cycle N appears on `PCResult` after edge N.
- Stall release latency is 1 cycle: with `Stall` low in cycle N, the pending target (or PC+4) appears after edge N.
- `Trap` is high for exactly one cycle, in the TRAP state. TRAP -> RUN (or HOLD if `Stall`) on the next edge.
- `TrapPC` holds its value until the next trap or reset.
- If a stall and a redirect are both asserted in the same RUN cycle, the redirect is captured as pending and the PC holds.

## Configuration

- `PC_ALIGN_TRAP_EN` defined: the block checks every selected jump, branch or pending target for bits [1:0] != 0 when it would load.
  - On a misaligned target: `PCResult` <= `TRAP_VECTOR`, `TrapPC` <= the target, `Trap`=1 for one cycle, state -> TRAP.
  - A misaligned target captured during HOLD traps when it is applied, not when it is captured.
- `PC_ALIGN_TRAP_EN` undefined: no check.
  - Target bits [1:0] are forced to 2'b00 on load.
  - `Trap` is tied to 0 and `TrapPC` to 0.
  - The TRAP state is absent.

## Test plan

- Reset and sequential fetch: hold `Reset`=0 for 3 cycles, then release, with `PCAddResult` driven as `PCResult`+4.
  - During reset: `PCResult`=0, `PCValid`=0.
  - After release: the sequence is 0, 4, 8, 12.
- Redirect priority: at `PCResult`=0x10, assert `Jump` (0x200) and `BranchTaken` (0x300) in the same cycle -> next `PCResult`=0x200. Then `BranchTaken` alone (0x300) -> 0x300.
- Stall with captured redirect, with `PCResult`=0x40:
  - Hold `Stall`=1 for 4 cycles; pulse `BranchTaken` (0x100) in stall cycle 2, then `Jump` (0x500) in stall cycle 3.
  - Required: `PCResult` stays 0x40; `RedirectPending`=1 from the edge after stall cycle 2.
  - On release: `PCResult`=0x500 and `RedirectPending`=0.
- Wrap-around: `PCResult`=0xFFFF_FFFC and `PCAddResult`=0 -> next `PCResult`=0 and `Trap`=0.
- Misaligned jump to 0x1002:
  - With `PC_ALIGN_TRAP_EN`: `PCResult`=0x80, `TrapPC`=0x1002, `Trap` high for exactly 1 cycle.
  - Without it: `PCResult`=0x1000 and `Trap`=0.
- Reset during a stall: with `RedirectPending`=1, assert `Reset`=0 for one edge.
  - Required: `PCResult`=`RESET_VECTOR`, `RedirectPending`=0, `PCValid`=0.
  - After release, fetch restarts at 0.

Source files
------------

// File: rtl/pc_register_unit.sv
// Program counter register with stall hold, pending redirect capture and
// optional misaligned-target trap (enabled by defining PC_ALIGN_TRAP_EN).
module pc_register_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCAddResult,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Stall,
  output logic [31:0] PCResult,
  output logic        PCValid,
  output logic        RedirectPending,
  output logic        Trap,
  output logic [31:0] TrapPC
);

`ifdef PC_ALIGN_TRAP_EN
  typedef enum logic [1:0] {
    ST_RST, ST_RUN, ST_HOLD, ST_TRAP
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_RST, ST_RUN, ST_HOLD
  } state_t;
`endif

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pend;
  logic [31:0] pend_nxt;
  logic        pend_v_nxt;
  logic [31:0] pc_nxt;
  logic        valid_nxt;

  logic        redirect;
  logic [31:0] redir_tgt;
  logic        load_tgt;
  logic [31:0] sel_tgt;
  logic        misalign;

  // Fresh redirect beats a pending one; jump beats branch.
  always_comb begin
    redirect  = Jump | BranchTaken;
    redir_tgt = Jump ? JumpTarget : BranchTarget;
    load_tgt  = redirect | RedirectPending;
    sel_tgt   = redirect ? redir_tgt : pend;
  end

`ifdef PC_ALIGN_TRAP_EN
  logic        trap_nxt;
  logic [31:0] trap_pc_nxt;

  // Misalignment is only judged on a target that is about to load.
  always_comb begin
    misalign = load_tgt && (sel_tgt[1:0] != 2'b00);
  end
`else
  logic unused_trap_vec;

  // No trap hardware: targets are simply truncated to word alignment.
  always_comb begin
    misalign        = 1'b0;
    unused_trap_vec = ^TRAP_VECTOR;
  end

  assign Trap   = 1'b0;
  assign TrapPC = 32'h0;
`endif

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset) state <= ST_RST;
    else        state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:  state_nxt = ST_RUN;
      default: begin
        if (Stall)
          state_nxt = ST_HOLD;
`ifdef PC_ALIGN_TRAP_EN
        else if (misalign)
          state_nxt = ST_TRAP;
`endif
        else
          state_nxt = ST_RUN;
      end
    endcase
  end

  // Next values of the PC, pending register and trap outputs.
  always_comb begin
    pc_nxt      = PCResult;
    valid_nxt   = 1'b1;
    pend_nxt    = pend;
    pend_v_nxt  = RedirectPending;
`ifdef PC_ALIGN_TRAP_EN
    trap_nxt    = 1'b0;
    trap_pc_nxt = TrapPC;
`endif
    if (state == ST_RST) begin
      pc_nxt = PCResult;
    end else if (Stall) begin
      if (redirect) begin
        pend_nxt   = redir_tgt;
        pend_v_nxt = 1'b1;
      end
    end else begin
      pend_v_nxt = 1'b0;
      if (misalign) begin
`ifdef PC_ALIGN_TRAP_EN
        pc_nxt      = TRAP_VECTOR;
        trap_nxt    = 1'b1;
        trap_pc_nxt = sel_tgt;
`endif
      end else if (load_tgt) begin
        pc_nxt = {sel_tgt[31:2], 2'b00};
      end else begin
        pc_nxt = {PCAddResult[31:2], 2'b00};
      end
    end
  end

  // Datapath registers; reset wins over every other update.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      PCResult        <= RESET_VECTOR;
      PCValid         <= 1'b0;
      RedirectPending <= 1'b0;
      pend            <= 32'h0;
    end else begin
      PCResult        <= pc_nxt;
      PCValid         <= valid_nxt;
      RedirectPending <= pend_v_nxt;
      pend            <= pend_nxt;
    end
  end

`ifdef PC_ALIGN_TRAP_EN
  // Trap pulse and offending-target capture.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Trap   <= 1'b0;
      TrapPC <= 32'h0;
    end else begin
      Trap   <= trap_nxt;
      TrapPC <= trap_pc_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_pc_register_unit.sv
// Randomized and directed checks of pc_register_unit against a
// behavioural model of the fetch-address rules.
module tb_pc_register_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0080;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PCAddResult;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Stall;
  logic [31:0] PCResult;
  logic        PCValid;
  logic        RedirectPending;
  logic        Trap;
  logic [31:0] TrapPC;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] m_pc = RV;
  logic        m_valid = 1'b0;
  logic        m_pv = 1'b0;
  logic [31:0] m_pend = 32'h0;
  logic        m_trap = 1'b0;
  logic [31:0] m_tpc = 32'h0;

  pc_register_unit #(
    .RESET_VECTOR(RV),
    .TRAP_VECTOR (TV)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .PCAddResult    (PCAddResult),
    .Jump           (Jump),
    .JumpTarget     (JumpTarget),
    .BranchTaken    (BranchTaken),
    .BranchTarget   (BranchTarget),
    .Stall          (Stall),
    .PCResult       (PCResult),
    .PCValid        (PCValid),
    .RedirectPending(RedirectPending),
    .Trap           (Trap),
    .TrapPC         (TrapPC)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Apply the fetch-address rules to the model for one clock edge.
  task automatic model_edge();
    logic [31:0] tgt;
    logic        have;
    if (!Reset) begin
      m_pc = RV; m_valid = 0; m_pv = 0;
      m_pend = 0; m_trap = 0; m_tpc = 0;
    end else if (!m_valid) begin
      m_valid = 1;
      m_trap = 0;
    end else begin
      m_trap = 0;
      if (Jump) tgt = JumpTarget;
      else if (BranchTaken) tgt = BranchTarget;
      else tgt = m_pend;
      have = Jump || BranchTaken || m_pv;
      if (Stall) begin
        if (Jump || BranchTaken) begin
          m_pend = tgt;
          m_pv = 1;
        end
      end else begin
        m_pv = 0;
        if (!have) begin
          m_pc = PCAddResult & ~32'd3;
        end else begin
`ifdef PC_ALIGN_TRAP_EN
          if (tgt[1:0] != 2'b00) begin
            m_pc = TV;
            m_trap = 1;
            m_tpc = tgt;
          end else begin
            m_pc = tgt;
          end
`else
          m_pc = tgt & ~32'd3;
`endif
        end
      end
    end
  endtask

  // One clock: sequential PC+4 from the model, edge, then compare all.
  task automatic tick(input string tag);
    PCAddResult = m_pc + 32'd4;
    #1;
    model_edge();
    @(posedge Clk);
    #1;
    chk({tag, ".pc"}, PCResult, m_pc);
    chk({tag, ".valid"}, {31'h0, PCValid}, {31'h0, m_valid});
    chk({tag, ".pend"}, {31'h0, RedirectPending}, {31'h0, m_pv});
    chk({tag, ".trap"}, {31'h0, Trap}, {31'h0, m_trap});
    chk({tag, ".trappc"}, TrapPC, m_tpc);
  endtask

  task automatic jump_to(input logic [31:0] a);
    Jump = 1; JumpTarget = a;
    tick("jmp");
    Jump = 0;
  endtask

  initial begin
    Reset = 0; Stall = 0; PCAddResult = 32'd4;
    Jump = 0; JumpTarget = 0;
    BranchTaken = 0; BranchTarget = 0;

    repeat (3) tick("rst");
    chk("rst_pc", PCResult, 32'h0);
    chk("rst_valid", {31'h0, PCValid}, 32'h0);
    Reset = 1;
    tick("rel");
    chk("first_pc", PCResult, 32'h0);
    tick("seq"); tick("seq"); tick("seq");
    chk("seq12", PCResult, 32'd12);

    jump_to(32'h10);
    Jump = 1; JumpTarget = 32'h200;
    BranchTaken = 1; BranchTarget = 32'h300;
    tick("prio");
    chk("prio_j", PCResult, 32'h200);
    Jump = 0;
    tick("br");
    chk("br_only", PCResult, 32'h300);
    BranchTaken = 0;

    jump_to(32'h40);
    Stall = 1;
    tick("st1");
    BranchTaken = 1; BranchTarget = 32'h100;
    tick("st2");
    BranchTaken = 0;
    chk("st2_pend", {31'h0, RedirectPending}, 32'h1);
    Jump = 1; JumpTarget = 32'h500;
    tick("st3");
    Jump = 0;
    tick("st4");
    chk("st_hold", PCResult, 32'h40);
    Stall = 0;
    tick("strel");
    chk("st_rel_pc", PCResult, 32'h500);
    chk("st_rel_pend", {31'h0, RedirectPending}, 32'h0);

    jump_to(32'hFFFF_FFFC);
    tick("wrap");
    chk("wrap_pc", PCResult, 32'h0);
    chk("wrap_trap", {31'h0, Trap}, 32'h0);

    jump_to(32'h1002);
`ifdef PC_ALIGN_TRAP_EN
    chk("mis_pc", PCResult, 32'h80);
    chk("mis_tpc", TrapPC, 32'h1002);
    chk("mis_trap", {31'h0, Trap}, 32'h1);
    tick("mis2");
    chk("mis_trap_off", {31'h0, Trap}, 32'h0);
`else
    chk("mis_pc", PCResult, 32'h1000);
    chk("mis_trap", {31'h0, Trap}, 32'h0);
`endif

    Stall = 1;
    jump_to(32'h700);
    chk("rs_pend", {31'h0, RedirectPending}, 32'h1);
    Reset = 0;
    tick("rs");
    chk("rs_pc", PCResult, RV);
    chk("rs_pend0", {31'h0, RedirectPending}, 32'h0);
    chk("rs_valid", {31'h0, PCValid}, 32'h0);
    Reset = 1; Stall = 0;
    tick("rsrel");
    tick("rsseq");
    chk("rs_restart", PCResult, 32'h4);

    for (int i = 0; i < 400; i++) begin
      Reset = ($urandom % 50) != 0;
      Stall = ($urandom % 4) == 0;
      Jump = ($urandom % 6) == 0;
      BranchTaken = ($urandom % 5) == 0;
      JumpTarget = $urandom;
      BranchTarget = $urandom;
      if ($urandom % 8 != 0) JumpTarget[1:0] = 2'b00;
      if ($urandom % 8 != 0) BranchTarget[1:0] = 2'b00;
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
